// File: rtl/packet_port_allocator_pkg.sv
// Shared flit-type codes and FSM state encoding for the per-output-port allocator.
package packet_port_allocator_pkg;

    localparam logic [2:0] FLIT_HEADER = 3'b001;
    localparam logic [2:0] FLIT_BODY   = 3'b010;
    localparam logic [2:0] FLIT_TAIL   = 3'b100;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/packet_port_allocator_rr_pick.sv
// Round-robin picker: rotates the eligible vector so the input after
// last_winner sits at bit 0, priority-encodes the lowest set bit, then
// rotates the result back into a one-hot winner.
module packet_port_allocator_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [PTR_W-1:0]   last_winner,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    logic [NUM_REQ-1:0] rotated;
    logic [PTR_W-1:0]   pos;

    // Index of the input that is 'offset' places past 'base', modulo NUM_REQ.
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int offset);
        return PTR_W'((int'(base) + offset) % NUM_REQ);
    endfunction

    // Rotate so that the highest-priority input (last_winner+1) lands on bit 0.
    always_comb begin
        rotated = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rotated[k] = eligible[wrap_idx(last_winner, k + 1)];
        end
    end

    // Lowest set bit of the rotated vector is the winner's rotated position.
    always_comb begin
        pos   = '0;
        valid = |rotated;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                pos = PTR_W'(k);
            end
        end
    end

    // Rotate the winning position back into absolute input numbering.
    always_comb begin
        winner = '0;
        if (valid) begin
            winner[wrap_idx(last_winner, int'(pos) + 1)] = 1'b1;
        end
    end

endmodule

// File: rtl/packet_port_allocator.sv
// Wormhole allocator for one router output port: grants the port round-robin
// to an input presenting a header flit and holds it for the packet's length.
module packet_port_allocator
    import packet_port_allocator_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       empty,
    input  logic [3*NUM_REQ-1:0]     flit_id,
    input  logic [LEN_W*NUM_REQ-1:0] length,
    input  logic                     dcts,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       sel,
    output logic                     busy,
    output logic                     pkt_done
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state, state_next;
    logic [NUM_REQ-1:0] sel_next;
    logic [PTR_W-1:0]   last_winner, last_winner_next;
    logic [LEN_W-1:0]   remaining, remaining_next;
    logic               pkt_done_next;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] winner;
    logic               win_valid;
    logic [LEN_W-1:0]   winner_len;
    logic [PTR_W-1:0]   owner_idx;
    logic               owner_ready;

    // An input competes only when it routes here and has a header at its FIFO head.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req[i] & ~empty[i] & (flit_id[3*i +: 3] == FLIT_HEADER);
        end
    end

    packet_port_allocator_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .eligible    (eligible),
        .last_winner (last_winner),
        .winner      (winner),
        .valid       (win_valid)
    );

    // Select the length field of the winning input (winner is one-hot).
    always_comb begin
        winner_len = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner[i]) begin
                winner_len = length[LEN_W*i +: LEN_W];
            end
        end
    end

    // Binary index of the current owner, used to advance the round-robin pointer.
    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel[i]) begin
                owner_idx = PTR_W'(i);
            end
        end
    end

    // A flit moves only when downstream has room and the owner's FIFO has data.
    always_comb begin
        owner_ready = dcts & ~(|(sel & empty));
        grant       = (state == ACTIVE) ? (sel & {NUM_REQ{owner_ready}}) : '0;
    end

    assign busy = (state == ACTIVE);

    // Next-state logic: claim the port on a header, count flits, release on the last one.
    always_comb begin
        state_next       = state;
        sel_next         = sel;
        last_winner_next = last_winner;
        remaining_next   = remaining;
        pkt_done_next    = 1'b0;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    state_next     = ACTIVE;
                    sel_next       = winner;
                    remaining_next = (winner_len == '0) ? LEN_W'(1) : winner_len;
                end
            end
            ACTIVE: begin
                if (|grant) begin
                    remaining_next = remaining - LEN_W'(1);
                    if (remaining == LEN_W'(1)) begin
                        state_next       = IDLE;
                        sel_next         = '0;
                        last_winner_next = owner_idx;
                        pkt_done_next    = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                sel_next   = '0;
            end
        endcase
    end

    // State, ownership, pointer and flit counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sel         <= '0;
            last_winner <= PTR_W'(NUM_REQ - 1);
            remaining   <= '0;
            pkt_done    <= 1'b0;
        end else begin
            state       <= state_next;
            sel         <= sel_next;
            last_winner <= last_winner_next;
            remaining   <= remaining_next;
            pkt_done    <= pkt_done_next;
        end
    end

endmodule

// File: tb/tb_packet_port_allocator.sv
// Scenario bench for packet_port_allocator: expected {grant,sel,busy,pkt_done}
// vectors are queued as stimulus is driven and checked at the falling edge.
module tb_packet_port_allocator;

    localparam int NUM_REQ = 4;
    localparam int LEN_W   = 12;
    localparam logic [2:0] HDR  = 3'b001;
    localparam logic [2:0] BODY = 3'b010;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ-1:0]       empty;
    logic [3*NUM_REQ-1:0]     flit_id;
    logic [LEN_W*NUM_REQ-1:0] length;
    logic                     dcts;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       sel;
    logic                     busy;
    logic                     pkt_done;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [9:0] exp_q[$];
    logic [9:0] got, want;

    packet_port_allocator #(
        .NUM_REQ (NUM_REQ),
        .LEN_W   (LEN_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .empty    (empty),
        .flit_id  (flit_id),
        .length   (length),
        .dcts     (dcts),
        .grant    (grant),
        .sel      (sel),
        .busy     (busy),
        .pkt_done (pkt_done)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Abort guard so the run can never hang
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    task automatic drive_inputs(input logic [3:0] r, input logic [3:0] e, input logic [11:0] f,
                                input logic [47:0] l, input logic d);
        req = r; empty = e; flit_id = f; length = l; dcts = d;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        drive_inputs('0, '1, '0, '0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive_inputs('0, '1, '0, '0, 1'b0);
        exp_q.push_back(10'b0);
        @(negedge clk);
        got = {grant, sel, busy, pkt_done}; want = exp_q.pop_front(); vectors++;
        if (got !== want) begin miscompares++; $display("[TB] FAIL reset_state: got %b want %b", got, want); end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.push_back(10'b0);
        @(negedge clk);
        got = {grant, sel, busy, pkt_done}; want = exp_q.pop_front(); vectors++;
        if (got !== want) begin miscompares++; $display("[TB] FAIL post_reset_idle: got %b want %b", got, want); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_packet;
        logic [11:0] f; logic [47:0] l; logic [3:0] g; logic b, p;
        for (int c = 0; c < 7; c++) begin
            f = '0; f[3 +: 3] = (c == 0) ? HDR : BODY;
            l = '0; l[12 +: 12] = 12'd4;
            drive_inputs((c == 0) ? 4'b0010 : 4'b0000, 4'b0000, f, l, 1'b1);
            b = (c >= 1 && c <= 4);
            g = b ? 4'b0010 : 4'b0000;
            p = (c == 5);
            exp_q.push_back({g, g, b, p});
            @(negedge clk);
            got = {grant, sel, busy, pkt_done}; want = exp_q.pop_front(); vectors++;
            if (got !== want) begin miscompares++; $display("[TB] FAIL single_pkt c%0d: got %b want %b", c, got, want); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_round_robin;
        logic [3:0] g; logic b, p; int k, ph;
        for (int c = 0; c < 16; c++) begin
            drive_inputs(4'b1111, 4'b0000, {4{HDR}}, {4{12'd2}}, 1'b1);
            k = (c - 1) / 3; ph = (c - 1) % 3;
            if (c == 0 || ph == 2) begin
                g = 4'b0000; b = 1'b0; p = (c != 0);
            end else begin
                g = 4'(1 << (k % 4)); b = 1'b1; p = 1'b0;
            end
            exp_q.push_back({g, g, b, p});
            @(negedge clk);
            got = {grant, sel, busy, pkt_done}; want = exp_q.pop_front(); vectors++;
            if (got !== want) begin miscompares++; $display("[TB] FAIL round_robin c%0d: got %b want %b", c, got, want); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure;
        logic [11:0] f; logic [47:0] l; logic [3:0] g, s; logic b, p;
        for (int c = 0; c < 11; c++) begin
            f = '0; f[0 +: 3] = (c == 0) ? HDR : BODY;
            l = '0; l[0 +: 12] = 12'd3;
            drive_inputs((c == 0) ? 4'b0001 : 4'b0000, 4'b0000, f, l, !(c >= 2 && c <= 6));
            b = (c >= 1 && c <= 8);
            s = b ? 4'b0001 : 4'b0000;
            g = (c == 1 || c == 7 || c == 8) ? 4'b0001 : 4'b0000;
            p = (c == 9);
            exp_q.push_back({g, s, b, p});
            @(negedge clk);
            got = {grant, sel, busy, pkt_done}; want = exp_q.pop_front(); vectors++;
            if (got !== want) begin miscompares++; $display("[TB] FAIL backpressure c%0d: got %b want %b", c, got, want); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_empty_stall;
        logic [3:0] r, e, g, s; logic [11:0] f; logic [47:0] l; logic b, p;
        for (int c = 0; c < 13; c++) begin
            r = 4'b0100; r[3] = (c >= 2);
            e = 4'b0000; e[2] = (c >= 3 && c <= 5);
            f = '0; f[6 +: 3] = (c == 0) ? HDR : BODY; f[9 +: 3] = HDR;
            l = '0; l[24 +: 12] = 12'd5; l[36 +: 12] = 12'd2;
            drive_inputs(r, e, f, l, 1'b1);
            if (c >= 1 && c <= 8) begin
                s = 4'b0100; b = 1'b1;
                g = (c == 1 || c == 2 || c >= 6) ? 4'b0100 : 4'b0000;
            end else if (c == 10 || c == 11) begin
                s = 4'b1000; b = 1'b1; g = 4'b1000;
            end else begin
                s = 4'b0000; b = 1'b0; g = 4'b0000;
            end
            p = (c == 9 || c == 12);
            exp_q.push_back({g, s, b, p});
            @(negedge clk);
            got = {grant, sel, busy, pkt_done}; want = exp_q.pop_front(); vectors++;
            if (got !== want) begin miscompares++; $display("[TB] FAIL empty_stall c%0d: got %b want %b", c, got, want); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_zero_length;
        logic [11:0] f; logic [3:0] g; logic b, p;
        for (int c = 0; c < 4; c++) begin
            f = '0; f[9 +: 3] = (c == 0) ? HDR : BODY;
            drive_inputs((c == 0) ? 4'b1000 : 4'b0000, 4'b0000, f, '0, 1'b1);
            b = (c == 1);
            g = b ? 4'b1000 : 4'b0000;
            p = (c == 2);
            exp_q.push_back({g, g, b, p});
            @(negedge clk);
            got = {grant, sel, busy, pkt_done}; want = exp_q.pop_front(); vectors++;
            if (got !== want) begin miscompares++; $display("[TB] FAIL zero_length c%0d: got %b want %b", c, got, want); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_packet;
        logic [11:0] f; logic [47:0] l; logic [3:0] g; logic b, p;
        for (int c = 0; c < 3; c++) begin
            f = '0; f[0 +: 3] = (c == 0) ? HDR : BODY;
            l = '0; l[0 +: 12] = 12'd6;
            drive_inputs((c == 0) ? 4'b0001 : 4'b0000, 4'b0000, f, l, 1'b1);
            b = (c >= 1);
            g = b ? 4'b0001 : 4'b0000;
            exp_q.push_back({g, g, b, 1'b0});
            @(negedge clk);
            got = {grant, sel, busy, pkt_done}; want = exp_q.pop_front(); vectors++;
            if (got !== want) begin miscompares++; $display("[TB] FAIL mid_pkt c%0d: got %b want %b", c, got, want); end
            if (c < 2) begin
                @(posedge clk); #1;
            end
        end
        #1 rst = 1'b1;
        exp_q.push_back(10'b0);
        #1;
        got = {grant, sel, busy, pkt_done}; want = exp_q.pop_front(); vectors++;
        if (got !== want) begin miscompares++; $display("[TB] FAIL async_reset: got %b want %b", got, want); end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive_inputs(4'b1111, 4'b0000, {4{HDR}}, {4{12'd1}}, 1'b1);
            b = (c == 1 || c == 3);
            g = (c == 1) ? 4'b0001 : ((c == 3) ? 4'b0010 : 4'b0000);
            p = (c == 2);
            exp_q.push_back({g, g, b, p});
            @(negedge clk);
            got = {grant, sel, busy, pkt_done}; want = exp_q.pop_front(); vectors++;
            if (got !== want) begin miscompares++; $display("[TB] FAIL restart_prio c%0d: got %b want %b", c, got, want); end
            @(posedge clk); #1;
        end
    endtask

    // Scenario sequence
    initial begin
        test_reset;
        test_single_packet;
        do_reset;
        test_round_robin;
        do_reset;
        test_backpressure;
        do_reset;
        test_empty_stall;
        do_reset;
        test_zero_length;
        do_reset;
        test_reset_mid_packet;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
